vproc_vregfile_xor: RTL and testbench
=====================================

# vproc_vregfile_xor

Parametrised XOR-based multi-ported vector register file for the vproc pipeline, generalising the fixed 32-register, combinational-read XOR file. Register count, read latency and post-reset clearing are configurable. Same-address write collisions are resolved per byte with a conflict flag. A clear state machine zeroes every bank after reset, so the first architectural read of any register returns 0.

## Interface
- `VREG_CNT`, 32: number of vector registers; power of two, ≥2.
- `VREG_W`, 128: register width in bits.
- `PORT_W`, 32: port width in bits; divides `VREG_W`, multiple of 8.
- `PORTS_RD`, 2: read ports, ≥1.
- `PORTS_WR`, 2: write ports, ≥1.
- `RD_REG`, 1: 0 = combinational read; 1 = registered read, 1-cycle latency.
- `CLEAR_ON_RESET`, 1: 1 = run the clear sequence after reset.
- Derived: `WPR = VREG_W/PORT_W`; `DEPTH = VREG_CNT*WPR`; `ADDR_W = $clog2(DEPTH)`. Word address = `{reg, word}`.
- `clk_i`  in  1  clock; the only clock.
- `sync_rst_i`  in  1  reset; synchronous, active-high.
- `wr_addr_i[PORTS_WR]`  in  ADDR_W  write word address.
- `wr_data_i[PORTS_WR]`  in  PORT_W  write data.
- `wr_be_i[PORTS_WR]`  in  PORT_W/8  byte enables.
- `wr_we_i[PORTS_WR]`  in  1  write enable.
- `rd_addr_i[PORTS_RD]`  in  ADDR_W  read word address.
- `rd_data_o[PORTS_RD]`  out  PORT_W  read data.
- `ready_o`  out  1  clear finished; writes accepted.
- `wr_conflict_o`  out  PORTS_WR  per-port flag: bytes were dropped in the previous cycle.

## Operation
- Storage: `PORTS_WR` rows × (`PORTS_RD+PORTS_WR-1`) bank copies of `DEPTH`×`PORT_W`.
  - Row w is written only by port w, and all copies in row w receive the same write.
  - The first `PORTS_RD` columns serve the external read ports.
  - The remaining columns are internal loop-back reads at the other write ports' addresses. The diagonal is omitted.
- Logical value = XOR of all rows at an address.
- Write on port w, byte b: row w stores `wr_data_i[w][b] ^ XOR(other rows at wr_addr_i[w])[b]`.
  - The loop-back reads are combinational and see pre-edge contents.
- Collision: enabled ports p<q, equal address, overlapping bytes.
  - The lower index wins; q's overlapping byte enables are masked.
  - `wr_conflict_o[q]` = 1 in the next cycle.
  - Non-overlapping bytes of both ports are written normally.
- Read-during-write to the same address returns the old data in both `RD_REG` modes. There is no forwarding.
- State machine `{VRF_CLEAR, VRF_READY}`:
  - Reset: enter VRF_CLEAR if `CLEAR_ON_RESET`, else VRF_READY. The counter is cleared to 0.
  - VRF_CLEAR, each cycle: write 0 to word `cnt` in every row and copy, all bytes; then `cnt++`.
  - VRF_CLEAR, at `cnt==DEPTH-1`: move to VRF_READY. The counter does not wrap.
  - VRF_CLEAR: external `wr_we_i` is ignored and no conflicts are flagged. `rd_data_o` is forced to 0.
  - VRF_READY: normal operation; leaves only on reset.
- Reset mid-clear: the counter restarts at 0 and clearing starts over.
- `CLEAR_ON_RESET=0`: contents are undefined (X in simulation) until written.

## Timing
- Reset values:
  - `ready_o` = 0 if `CLEAR_ON_RESET`, else 1.
  - `wr_conflict_o` = 0.
  - `rd_data_o` = 0 when `RD_REG=1`; when `RD_REG=0`, forced to 0 while in VRF_CLEAR.
- Clear duration:
  - The first clear write happens at the first edge with `sync_rst_i` low.
  - `ready_o` rises after exactly `DEPTH` such edges (default config: 32·4 = 128).
- Write latency: data is visible on a combinational read in the cycle after the write edge. With `RD_REG=1` it appears one cycle later still.
- `RD_REG=0`: `rd_data_o` follows `rd_addr_i` in the same cycle.
- `RD_REG=1`: address sampled at edge k, data valid after edge k and held until edge k+1.
- `wr_conflict_o`: registered; a pulse lasts one cycle per colliding cycle.
- Throughput: every write port and every read port can be used every cycle.

## Structure
- `vproc_pkg` additions:
  - `vregfile_state_t` enum {VRF_CLEAR, VRF_READY}.
  - A function computing `ADDR_W` from `VREG_CNT`, `VREG_W`, `PORT_W`.
- Sub-module `vproc_vregfile_xor_bank`: one row (one write port, byte enables, `PORTS_RD+PORTS_WR-1` combinational read ports).
  - Instantiated `PORTS_WR` times.
  - The top level holds the write-data composition, collision masking, clear FSM, output XOR and optional read registers.

## Test plan
1. Clear completes, default config: deassert reset, count cycles → `ready_o` rises after 128; reading all 128 words returns 0.
2. Independent writes: WP0 writes 0xDEADBEEF to addr 5 while WP1 writes 0x12345678 to addr 9 → next cycle RP0 (addr 5) = 0xDEADBEEF and RP1 (addr 9) = 0x12345678.
3. Repeated cross-port overwrite: WP1 writes 0xAAAAAAAA to addr 3, then WP0 writes 0x55555555 to addr 3 → reads 0x55555555, proving the XOR composition.
4. Collision:
   - WP0 writes 0x11111111 with be=0011 and WP1 writes 0x22222222 with be=0110, both to addr 7 (previous contents 0).
   - Result: 0x00221111; `wr_conflict_o` = 0b10 for one cycle.
5. `RD_REG=1`, read during write: read addr 2 in the same cycle WP0 writes 0xCAFE0000 there → next cycle old value 0; the following read returns 0xCAFE0000.
6. Reset mid-clear: assert reset at cycle 60 of the clear → `ready_o` stays 0 and rises 128 cycles after release; `wr_we_i` pulses during the clear do not change any contents.

Source files
------------

// File: rtl/vproc_vregfile_xor_pkg.sv
// Shared types and helpers for the XOR-based multi-ported vector register file.
package vproc_vregfile_xor_pkg;

  typedef enum logic {
    VRF_CLEAR = 1'b0,
    VRF_READY = 1'b1
  } vregfile_state_t;

  // Word address width: one address per PORT_W-wide slice of every register.
  function automatic int unsigned vreg_addr_w(input int unsigned vreg_cnt,
                                              input int unsigned vreg_w,
                                              input int unsigned port_w);
    return $clog2(vreg_cnt * (vreg_w / port_w));
  endfunction

endpackage

// File: rtl/vproc_vregfile_xor_if.sv
// Port bundle of the vector register file: write ports, read ports and status.
interface vproc_vregfile_xor_if
  import vproc_vregfile_xor_pkg::*;
#(
  parameter int unsigned VREG_CNT = 32,
  parameter int unsigned VREG_W   = 128,
  parameter int unsigned PORT_W   = 32,
  parameter int unsigned PORTS_RD = 2,
  parameter int unsigned PORTS_WR = 2
) ();

  localparam int unsigned ADDR_W = vreg_addr_w(VREG_CNT, VREG_W, PORT_W);
  localparam int unsigned BE_W   = PORT_W / 8;

  logic [ADDR_W-1:0]   wr_addr_i     [PORTS_WR];
  logic [PORT_W-1:0]   wr_data_i     [PORTS_WR];
  logic [BE_W-1:0]     wr_be_i       [PORTS_WR];
  logic                wr_we_i       [PORTS_WR];
  logic [ADDR_W-1:0]   rd_addr_i     [PORTS_RD];
  logic [PORT_W-1:0]   rd_data_o     [PORTS_RD];
  logic                ready_o;
  logic [PORTS_WR-1:0] wr_conflict_o;

  modport master (
    output wr_addr_i, wr_data_i, wr_be_i, wr_we_i, rd_addr_i,
    input  rd_data_o, ready_o, wr_conflict_o
  );

  modport slave (
    input  wr_addr_i, wr_data_i, wr_be_i, wr_we_i, rd_addr_i,
    output rd_data_o, ready_o, wr_conflict_o
  );

endinterface

// File: rtl/vproc_vregfile_xor_bank.sv
// One row of the XOR file: a single byte-enabled write port replicated into
// RD_CNT identical copies, each with its own combinational read port.
module vproc_vregfile_xor_bank #(
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned PORT_W = 32,
  parameter int unsigned RD_CNT = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PORT_W-1:0] wr_data,
  input  logic [PORT_W/8-1:0] wr_be,
  input  logic [ADDR_W-1:0] rd_addr [RD_CNT],
  output logic [PORT_W-1:0] rd_data [RD_CNT]
);

  for (genvar c = 0; c < RD_CNT; c++) begin : g_copy
    logic [PORT_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (we) begin
        for (int b = 0; b < PORT_W / 8; b++) begin
          if (wr_be[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end

    assign rd_data[c] = mem[rd_addr[c]];
  end

endmodule

// File: rtl/vproc_vregfile_xor.sv
// XOR-based multi-ported vector register file with per-byte collision
// resolution, optional registered reads and a post-reset clear sequence.
module vproc_vregfile_xor
  import vproc_vregfile_xor_pkg::*;
#(
  parameter int unsigned VREG_CNT       = 32,
  parameter int unsigned VREG_W         = 128,
  parameter int unsigned PORT_W         = 32,
  parameter int unsigned PORTS_RD       = 2,
  parameter int unsigned PORTS_WR       = 2,
  parameter bit          RD_REG         = 1'b1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic             clk_i,
  input  logic             sync_rst_i,
  vproc_vregfile_xor_if.slave vrf
);

  localparam int unsigned WPR    = VREG_W / PORT_W;
  localparam int unsigned DEPTH  = VREG_CNT * WPR;
  localparam int unsigned ADDR_W = vreg_addr_w(VREG_CNT, VREG_W, PORT_W);
  localparam int unsigned BE_W   = PORT_W / 8;
  localparam int unsigned NCOL   = PORTS_RD + PORTS_WR - 1;

  vregfile_state_t     state;
  logic [ADDR_W-1:0]   cnt;
  logic                ready_q;
  logic [PORTS_WR-1:0] conf_q;
  logic [PORTS_WR-1:0] conf_comb;
  logic                clearing;

  logic [ADDR_W-1:0] bank_raddr [PORTS_WR][NCOL];
  logic [PORT_W-1:0] bank_rdata [PORTS_WR][NCOL];
  logic              bank_we    [PORTS_WR];
  logic [ADDR_W-1:0] bank_waddr [PORTS_WR];
  logic [PORT_W-1:0] bank_wdata [PORTS_WR];
  logic [BE_W-1:0]   bank_be    [PORTS_WR];

  logic [BE_W-1:0]   be_eff     [PORTS_WR];
  logic [PORT_W-1:0] wdata_xor  [PORTS_WR];
  logic [PORT_W-1:0] rd_xor     [PORTS_RD];

  assign clearing          = (state == VRF_CLEAR);
  assign vrf.ready_o       = ready_q;
  assign vrf.wr_conflict_o = conf_q;

  // Columns past the external read ports look up the other write ports'
  // addresses; the row's own write port is skipped.
  always_comb begin
    for (int w = 0; w < int'(PORTS_WR); w++) begin
      for (int c = 0; c < int'(PORTS_RD); c++) bank_raddr[w][c] = vrf.rd_addr_i[c];
      for (int j = 0; j < int'(PORTS_WR) - 1; j++) begin
        bank_raddr[w][int'(PORTS_RD) + j] = (j < w) ? vrf.wr_addr_i[j] : vrf.wr_addr_i[j+1];
      end
    end
  end

  // Lower-indexed enabled ports win overlapping bytes at the same address.
  always_comb begin
    logic [BE_W-1:0] mask;
    conf_comb = '0;
    for (int q = 0; q < int'(PORTS_WR); q++) begin
      mask = '0;
      for (int p = 0; p < q; p++) begin
        if (vrf.wr_we_i[p] && (vrf.wr_addr_i[p] == vrf.wr_addr_i[q])) mask |= vrf.wr_be_i[p];
      end
      be_eff[q]    = vrf.wr_be_i[q] & ~mask;
      conf_comb[q] = vrf.wr_we_i[q] && ((vrf.wr_be_i[q] & mask) != '0);
    end
  end

  always_comb begin
    int col;
    for (int w = 0; w < int'(PORTS_WR); w++) begin
      wdata_xor[w] = vrf.wr_data_i[w];
      for (int v = 0; v < int'(PORTS_WR); v++) begin
        if (v != w) begin
          col          = int'(PORTS_RD) + ((v > w) ? w : w - 1);
          wdata_xor[w] ^= bank_rdata[v][col];
        end
      end
    end
  end

  always_comb begin
    for (int w = 0; w < int'(PORTS_WR); w++) begin
      bank_we[w]    = clearing ? 1'b1 : vrf.wr_we_i[w];
      bank_waddr[w] = clearing ? cnt : vrf.wr_addr_i[w];
      bank_wdata[w] = clearing ? '0 : wdata_xor[w];
      bank_be[w]    = clearing ? '1 : be_eff[w];
    end
  end

  for (genvar w = 0; w < PORTS_WR; w++) begin : g_row
    vproc_vregfile_xor_bank #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .PORT_W (PORT_W),
      .RD_CNT (NCOL)
    ) u_bank (
      .clk     (clk_i),
      .we      (bank_we[w]),
      .wr_addr (bank_waddr[w]),
      .wr_data (bank_wdata[w]),
      .wr_be   (bank_be[w]),
      .rd_addr (bank_raddr[w]),
      .rd_data (bank_rdata[w])
    );
  end

  always_comb begin
    for (int r = 0; r < int'(PORTS_RD); r++) begin
      rd_xor[r] = '0;
      for (int v = 0; v < int'(PORTS_WR); v++) rd_xor[r] ^= bank_rdata[v][r];
    end
  end

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      state   <= CLEAR_ON_RESET ? VRF_CLEAR : VRF_READY;
      cnt     <= '0;
      ready_q <= !CLEAR_ON_RESET;
      conf_q  <= '0;
    end else begin
      case (state)
        VRF_CLEAR: begin
          conf_q <= '0;
          if (cnt == ADDR_W'(DEPTH - 1)) begin
            state   <= VRF_READY;
            ready_q <= 1'b1;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        VRF_READY: conf_q <= conf_comb;
        default:   state  <= VRF_READY;
      endcase
    end
  end

  if (RD_REG) begin : g_rd_reg
    logic [PORT_W-1:0] rd_q [PORTS_RD];

    always_ff @(posedge clk_i) begin
      for (int r = 0; r < int'(PORTS_RD); r++) begin
        if (sync_rst_i) rd_q[r] <= '0;
        else            rd_q[r] <= clearing ? '0 : rd_xor[r];
      end
    end

    for (genvar r = 0; r < PORTS_RD; r++) begin : g_out
      assign vrf.rd_data_o[r] = rd_q[r];
    end
  end else begin : g_rd_comb
    for (genvar r = 0; r < PORTS_RD; r++) begin : g_out
      assign vrf.rd_data_o[r] = clearing ? '0 : rd_xor[r];
    end
  end

endmodule

// File: tb/tb_vproc_vregfile_xor.sv
// Directed bench for the XOR register file in its default configuration.
module tb_vproc_vregfile_xor;

  logic clk;
  logic sync_rst;
  int   checks;
  int   failures;

  vproc_vregfile_xor_if #(
    .VREG_CNT(32), .VREG_W(128), .PORT_W(32), .PORTS_RD(2), .PORTS_WR(2)
  ) vrf ();

  vproc_vregfile_xor #(
    .VREG_CNT(32), .VREG_W(128), .PORT_W(32), .PORTS_RD(2), .PORTS_WR(2),
    .RD_REG(1'b1), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk_i      (clk),
    .sync_rst_i (sync_rst),
    .vrf        (vrf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we0;
    logic [6:0]  a0;
    logic [31:0] d0;
    logic [3:0]  be0;
    logic        we1;
    logic [6:0]  a1;
    logic [31:0] d1;
    logic [3:0]  be1;
    logic [6:0]  r0;
    logic [6:0]  r1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  ec;
  } vec_t;

  vec_t vecs[9];

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    vrf.wr_we_i[0] = 1'b0;
    vrf.wr_we_i[1] = 1'b0;
  endtask

  task automatic drive(input int p, input logic [6:0] a, input logic [31:0] d, input logic [3:0] be);
    vrf.wr_we_i[p]   = 1'b1;
    vrf.wr_addr_i[p] = a;
    vrf.wr_data_i[p] = d;
    vrf.wr_be_i[p]   = be;
  endtask

  initial begin
    int n;
    checks   = 0;
    failures = 0;
    sync_rst = 1'b1;
    for (int p = 0; p < 2; p++) begin
      vrf.wr_we_i[p]   = 1'b0;
      vrf.wr_addr_i[p] = '0;
      vrf.wr_data_i[p] = '0;
      vrf.wr_be_i[p]   = '0;
      vrf.rd_addr_i[p] = '0;
    end

    //             we0 a0   d0            be0  we1 a1   d1            be1  r0   r1   e0            e1            ec
    vecs[0] = '{1, 7'd5,  32'hDEADBEEF, 4'hF, 1, 7'd9,  32'h12345678, 4'hF, 7'd5,  7'd9,  32'hDEADBEEF, 32'h12345678, 2'b00};
    vecs[1] = '{0, 7'd0,  32'h0,        4'h0, 1, 7'd3,  32'hAAAAAAAA, 4'hF, 7'd3,  7'd3,  32'hAAAAAAAA, 32'hAAAAAAAA, 2'b00};
    vecs[2] = '{1, 7'd3,  32'h55555555, 4'hF, 0, 7'd0,  32'h0,        4'h0, 7'd3,  7'd5,  32'h55555555, 32'hDEADBEEF, 2'b00};
    vecs[3] = '{1, 7'd7,  32'h11111111, 4'h3, 1, 7'd7,  32'h22222222, 4'h6, 7'd7,  7'd3,  32'h00221111, 32'h55555555, 2'b10};
    vecs[4] = '{0, 7'd0,  32'h0,        4'h0, 1, 7'd5,  32'h77000000, 4'h8, 7'd5,  7'd9,  32'h77ADBEEF, 32'h12345678, 2'b00};
    vecs[5] = '{1, 7'd20, 32'h000000AB, 4'h1, 1, 7'd20, 32'hCD000000, 4'h8, 7'd20, 7'd21, 32'hCD0000AB, 32'h00000000, 2'b00};
    vecs[6] = '{1, 7'd9,  32'h0BADF00D, 4'hF, 1, 7'd9,  32'hFFFFFFFF, 4'hF, 7'd9,  7'd7,  32'h0BADF00D, 32'h00221111, 2'b10};
    vecs[7] = '{0, 7'd0,  32'h0,        4'h0, 1, 7'd127,32'h13579BDF, 4'hF, 7'd127,7'd0,  32'h13579BDF, 32'h00000000, 2'b00};
    vecs[8] = '{0, 7'd30, 32'hFFFFFFFF, 4'hF, 1, 7'd30, 32'h01020304, 4'hF, 7'd30, 7'd127,32'h01020304, 32'h13579BDF, 2'b00};

    // Reset values
    cycle(); cycle(); cycle();
    check("rst_ready", 32'(vrf.ready_o), 32'd0);
    check("rst_conflict", 32'(vrf.wr_conflict_o), 32'd0);
    check("rst_rd0", vrf.rd_data_o[0], 32'd0);
    check("rst_rd1", vrf.rd_data_o[1], 32'd0);

    // Clear duration
    sync_rst = 1'b0;
    n = 0;
    while (!vrf.ready_o && n < 300) begin
      cycle();
      n++;
    end
    check("clear_cycles", 32'(n), 32'd128);

    for (int a = 0; a < 64; a++) begin
      vrf.rd_addr_i[0] = 7'(a);
      vrf.rd_addr_i[1] = 7'(a + 64);
      cycle();
      check("clear_zero_rp0", vrf.rd_data_o[0], 32'd0);
      check("clear_zero_rp1", vrf.rd_data_o[1], 32'd0);
    end

    // Table-driven writes, collisions and readback
    for (int i = 0; i < 9; i++) begin
      vrf.wr_we_i[0]   = vecs[i].we0;
      vrf.wr_addr_i[0] = vecs[i].a0;
      vrf.wr_data_i[0] = vecs[i].d0;
      vrf.wr_be_i[0]   = vecs[i].be0;
      vrf.wr_we_i[1]   = vecs[i].we1;
      vrf.wr_addr_i[1] = vecs[i].a1;
      vrf.wr_data_i[1] = vecs[i].d1;
      vrf.wr_be_i[1]   = vecs[i].be1;
      cycle();
      check($sformatf("vec%0d_conflict", i), 32'(vrf.wr_conflict_o), 32'(vecs[i].ec));
      idle();
      vrf.rd_addr_i[0] = vecs[i].r0;
      vrf.rd_addr_i[1] = vecs[i].r1;
      cycle();
      check($sformatf("vec%0d_rd0", i), vrf.rd_data_o[0], vecs[i].e0);
      check($sformatf("vec%0d_rd1", i), vrf.rd_data_o[1], vecs[i].e1);
      check($sformatf("vec%0d_conflict_end", i), 32'(vrf.wr_conflict_o), 32'd0);
    end

    // Read during write returns old data, new data on the following read
    vrf.rd_addr_i[0] = 7'd2;
    drive(0, 7'd2, 32'hCAFE0000, 4'hF);
    cycle();
    check("rdw_old", vrf.rd_data_o[0], 32'd0);
    idle();
    cycle();
    check("rdw_new", vrf.rd_data_o[0], 32'hCAFE0000);

    // Back-to-back collisions hold the flag for each colliding cycle
    drive(0, 7'd40, 32'h01010101, 4'hF);
    drive(1, 7'd40, 32'hF0F0F0F0, 4'hF);
    cycle();
    check("b2b_conflict1", 32'(vrf.wr_conflict_o), 32'd2);
    drive(0, 7'd40, 32'h02020202, 4'hF);
    cycle();
    check("b2b_conflict2", 32'(vrf.wr_conflict_o), 32'd2);
    idle();
    vrf.rd_addr_i[0] = 7'd40;
    cycle();
    check("b2b_conflict_end", 32'(vrf.wr_conflict_o), 32'd0);
    cycle();
    check("b2b_data", vrf.rd_data_o[0], 32'h02020202);

    // Reset mid-clear
    sync_rst = 1'b1;
    cycle();
    sync_rst = 1'b0;
    vrf.rd_addr_i[0] = 7'd127;
    for (int c = 1; c <= 60; c++) begin
      cycle();
      if (c == 30) begin
        check("clear_rd_forced", vrf.rd_data_o[0], 32'd0);
        check("clear_ready_low", 32'(vrf.ready_o), 32'd0);
      end
    end
    sync_rst = 1'b1;
    cycle();
    cycle();
    check("midrst_ready", 32'(vrf.ready_o), 32'd0);
    sync_rst = 1'b0;
    n = 0;
    while (!vrf.ready_o && n < 300) begin
      if (n >= 10 && n < 20) begin
        drive(0, 7'd5, 32'hA5A5A5A5, 4'hF);
        drive(1, 7'd5, 32'h5A5A5A5A, 4'hF);
      end else begin
        idle();
      end
      cycle();
      n++;
      if (n == 15) check("clear_no_conflict", 32'(vrf.wr_conflict_o), 32'd0);
    end
    idle();
    check("midrst_clear_cycles", 32'(n), 32'd128);
    vrf.rd_addr_i[0] = 7'd5;
    vrf.rd_addr_i[1] = 7'd127;
    cycle();
    check("midrst_addr5", vrf.rd_data_o[0], 32'd0);
    check("midrst_addr127", vrf.rd_data_o[1], 32'd0);
    vrf.rd_addr_i[0] = 7'd40;
    vrf.rd_addr_i[1] = 7'd7;
    cycle();
    check("midrst_addr40", vrf.rd_data_o[0], 32'd0);
    check("midrst_addr7", vrf.rd_data_o[1], 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
